// File: rtl/fb_reader.sv
// Framebuffer reader: fetches one 32-bit pixel per single-beat bus read and
// pushes it into the display FIFO, walking the frame in raster order.
module fb_reader #(
    parameter logic [31:0] FB_BASE  = 32'h0000_0000,
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned V_LINES  = 480
) (
    input  logic        PLB_clk,
    input  logic        reset,
    input  logic        enable,
    output logic        IP2Bus_MstRd_Req,
    output logic [31:0] IP2Bus_Mst_Addr,
    output logic        IP2Bus_MstRd_dst_rdy_n,
    input  logic        Bus2IP_Mst_CmdAck,
    input  logic        Bus2IP_Mst_Cmplt,
    input  logic        Bus2IP_Mst_Error,
    input  logic [31:0] Bus2IP_MstRd_d,
    input  logic        Bus2IP_MstRd_src_rdy_n,
    output logic [31:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        frame_done,
    output logic        rd_error
);

    localparam logic [19:0] LAST_PIX = 20'(H_PIXELS * V_LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_PUSH
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [19:0] r_pix_cnt;
    logic [31:0] r_data;
    logic        w_last_pix;

    assign w_last_pix = (r_pix_cnt == LAST_PIX);

    always_ff @(posedge PLB_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (enable && !fifo_full) w_next = S_REQ;
            S_REQ:  if (Bus2IP_Mst_CmdAck) w_next = S_DATA;
            S_DATA: begin
                if (Bus2IP_Mst_Cmplt) begin
                    w_next = Bus2IP_Mst_Error ? S_IDLE : S_PUSH;
                end
            end
            S_PUSH: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge PLB_clk or negedge reset) begin
        if (!reset) begin
            r_pix_cnt <= '0;
        end else if (r_state == S_PUSH) begin
            r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 20'd1;
        end
    end

    // An errored read may still overwrite r_data; it is never pushed, and the
    // retry recaptures the word before the next PUSH.
    always_ff @(posedge PLB_clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (r_state == S_DATA && !Bus2IP_MstRd_src_rdy_n) begin
            r_data <= Bus2IP_MstRd_d;
        end
    end

    assign IP2Bus_MstRd_Req       = (r_state == S_REQ);
    assign IP2Bus_Mst_Addr        = FB_BASE + {10'd0, r_pix_cnt, 2'b00};
    assign IP2Bus_MstRd_dst_rdy_n = (r_state != S_DATA);
    assign fifo_din               = r_data;
    assign fifo_wr_en             = (r_state == S_PUSH);
    assign frame_done             = (r_state == S_PUSH) && w_last_pix;
    assign rd_error               = (r_state == S_DATA) && Bus2IP_Mst_Cmplt && Bus2IP_Mst_Error;

endmodule

// File: tb/tb_fb_reader.sv
// Randomized self-checking bench for fb_reader: a bus responder task drives
// reads and a pixel-index model predicts addresses, FIFO words and frame ends.
module tb_fb_reader;

    localparam logic [31:0] TB_BASE = 32'hFFFF_FFF0;
    localparam int unsigned TB_H    = 4;
    localparam int unsigned TB_V    = 2;
    localparam int unsigned NPIX    = TB_H * TB_V;

    logic        PLB_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        IP2Bus_MstRd_Req;
    logic [31:0] IP2Bus_Mst_Addr;
    logic        IP2Bus_MstRd_dst_rdy_n;
    logic        Bus2IP_Mst_CmdAck;
    logic        Bus2IP_Mst_Cmplt;
    logic        Bus2IP_Mst_Error;
    logic [31:0] Bus2IP_MstRd_d;
    logic        Bus2IP_MstRd_src_rdy_n;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        frame_done;
    logic        rd_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int unsigned exp_pix  = 0;

    fb_reader #(
        .FB_BASE (TB_BASE),
        .H_PIXELS(TB_H),
        .V_LINES (TB_V)
    ) dut (
        .PLB_clk               (PLB_clk),
        .reset                 (reset),
        .enable                (enable),
        .IP2Bus_MstRd_Req      (IP2Bus_MstRd_Req),
        .IP2Bus_Mst_Addr       (IP2Bus_Mst_Addr),
        .IP2Bus_MstRd_dst_rdy_n(IP2Bus_MstRd_dst_rdy_n),
        .Bus2IP_Mst_CmdAck     (Bus2IP_Mst_CmdAck),
        .Bus2IP_Mst_Cmplt      (Bus2IP_Mst_Cmplt),
        .Bus2IP_Mst_Error      (Bus2IP_Mst_Error),
        .Bus2IP_MstRd_d        (Bus2IP_MstRd_d),
        .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
        .fifo_din              (fifo_din),
        .fifo_wr_en            (fifo_wr_en),
        .fifo_full             (fifo_full),
        .frame_done            (frame_done),
        .rd_error              (rd_error)
    );

    always #5 PLB_clk = ~PLB_clk;
    always @(posedge PLB_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] addr_of(input int unsigned p);
        return TB_BASE + 32'(p) * 32'd4;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},     {31'd0, IP2Bus_MstRd_Req}, 32'd0);
        check_eq({tag, "_addr"},    IP2Bus_Mst_Addr, TB_BASE);
        check_eq({tag, "_dstrdy"},  {31'd0, IP2Bus_MstRd_dst_rdy_n}, 32'd1);
        check_eq({tag, "_din"},     fifo_din, 32'd0);
        check_eq({tag, "_wr"},      {31'd0, fifo_wr_en}, 32'd0);
        check_eq({tag, "_frame"},   {31'd0, frame_done}, 32'd0);
        check_eq({tag, "_rderr"},   {31'd0, rd_error}, 32'd0);
    endtask

    task automatic clear_bus;
        Bus2IP_Mst_CmdAck      = 1'b0;
        Bus2IP_Mst_Cmplt       = 1'b0;
        Bus2IP_Mst_Error       = 1'b0;
        Bus2IP_MstRd_src_rdy_n = 1'b1;
        Bus2IP_MstRd_d         = '0;
    endtask

    // One read from request to FIFO push (or error), with configurable latencies.
    task automatic serve(input int ack_lat, input int cmp_lat, input bit err, input bit drop_en,
                         output int waited, output int wr_cyc);
        logic [31:0] word;
        int          dcyc;
        bit          got;
        word   = $urandom;
        dcyc   = $urandom_range(cmp_lat, 0);
        waited = 0;
        got    = 1'b0;
        wr_cyc = -1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge PLB_clk);
            waited++;
            if (IP2Bus_MstRd_Req) got = 1'b1;
        end
        if (!got) begin
            check_eq("req_timeout", 32'd0, 32'd1);
            return;
        end
        check_eq("req_addr", IP2Bus_Mst_Addr, addr_of(exp_pix));
        check_eq("dstrdy_in_req", {31'd0, IP2Bus_MstRd_dst_rdy_n}, 32'd1);
        for (int i = 0; i < ack_lat; i++) begin
            Bus2IP_Mst_Cmplt = 1'($urandom);
            Bus2IP_Mst_Error = 1'($urandom);
            @(negedge PLB_clk);
            Bus2IP_Mst_Cmplt = 1'b0;
            Bus2IP_Mst_Error = 1'b0;
            check_eq("req_held", {31'd0, IP2Bus_MstRd_Req}, 32'd1);
            check_eq("addr_held", IP2Bus_Mst_Addr, addr_of(exp_pix));
        end
        Bus2IP_Mst_CmdAck = 1'b1;
        @(negedge PLB_clk);
        Bus2IP_Mst_CmdAck = 1'b0;
        check_eq("req_drop_after_ack", {31'd0, IP2Bus_MstRd_Req}, 32'd0);
        for (int c = 0; c <= cmp_lat; c++) begin
            check_eq("dstrdy_in_data", {31'd0, IP2Bus_MstRd_dst_rdy_n}, 32'd0);
            if (drop_en && c == 0) enable = 1'b0;
            Bus2IP_MstRd_src_rdy_n = (c == dcyc) ? 1'b0 : 1'b1;
            Bus2IP_MstRd_d         = (c == dcyc) ? word : $urandom;
            Bus2IP_Mst_Cmplt       = (c == cmp_lat);
            Bus2IP_Mst_Error       = (c == cmp_lat) && err;
            #1;
            check_eq("rd_error", {31'd0, rd_error}, {31'd0, (c == cmp_lat) && err});
            check_eq("no_wr_in_data", {31'd0, fifo_wr_en}, 32'd0);
            @(negedge PLB_clk);
        end
        clear_bus();
        if (err) begin
            check_eq("err_no_wr", {31'd0, fifo_wr_en}, 32'd0);
            check_eq("err_no_req", {31'd0, IP2Bus_MstRd_Req}, 32'd0);
        end else begin
            check_eq("wr_en", {31'd0, fifo_wr_en}, 32'd1);
            check_eq("fifo_din", fifo_din, word);
            check_eq("frame_done", {31'd0, frame_done}, {31'd0, exp_pix == NPIX - 1});
            check_eq("dstrdy_in_push", {31'd0, IP2Bus_MstRd_dst_rdy_n}, 32'd1);
            wr_cyc  = cyc;
            exp_pix = (exp_pix + 1) % NPIX;
            @(negedge PLB_clk);
            check_eq("wr_one_cycle", {31'd0, fifo_wr_en}, 32'd0);
            check_eq("frame_one_cycle", {31'd0, frame_done}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  w;
        int  wc;
        int  prev_wc;
        bit  got;

        reset     = 1'b0;
        enable    = 1'b0;
        fifo_full = 1'b0;
        clear_bus();
        repeat (3) @(negedge PLB_clk);
        check_reset_outputs("reset");

        reset  = 1'b1;
        enable = 1'b1;

        // Back-to-back single-cycle responses: throughput, frame wrap, address overflow.
        prev_wc = -1;
        for (int i = 0; i < 10; i++) begin
            serve(0, 0, 1'b0, 1'b0, w, wc);
            if (prev_wc >= 0) check_eq("throughput", 32'(wc - prev_wc), 32'd4);
            prev_wc = wc;
        end

        // FIFO full held in IDLE.
        fifo_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge PLB_clk);
            check_eq("full_no_req", {31'd0, IP2Bus_MstRd_Req}, 32'd0);
            check_eq("full_no_wr", {31'd0, fifo_wr_en}, 32'd0);
        end
        fifo_full = 1'b0;
        serve(0, 0, 1'b0, 1'b0, w, wc);
        check_eq("req_after_full", 32'(w), 32'd1);

        // Errored read on pixel 3, then retry at the same address.
        check_eq("model_at_pix3", exp_pix, 32'd3);
        serve(1, 2, 1'b1, 1'b0, w, wc);
        serve(0, 1, 1'b0, 1'b0, w, wc);

        // Enable dropped during DATA; stray strobes while idle are ignored.
        serve(0, 2, 1'b0, 1'b1, w, wc);
        for (int i = 0; i < 12; i++) begin
            Bus2IP_Mst_CmdAck = 1'($urandom);
            Bus2IP_Mst_Cmplt  = 1'($urandom);
            Bus2IP_Mst_Error  = 1'($urandom);
            @(negedge PLB_clk);
            check_eq("disabled_no_req", {31'd0, IP2Bus_MstRd_Req}, 32'd0);
            check_eq("disabled_no_wr", {31'd0, fifo_wr_en}, 32'd0);
            check_eq("disabled_no_err", {31'd0, rd_error}, 32'd0);
        end
        clear_bus();
        enable = 1'b1;
        serve(0, 0, 1'b0, 1'b0, w, wc);

        // Reset asserted while data is arriving.
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge PLB_clk);
            if (IP2Bus_MstRd_Req) got = 1'b1;
        end
        check_eq("rst_req_seen", {31'd0, got}, 32'd1);
        Bus2IP_Mst_CmdAck = 1'b1;
        @(negedge PLB_clk);
        Bus2IP_Mst_CmdAck      = 1'b0;
        Bus2IP_MstRd_src_rdy_n = 1'b0;
        Bus2IP_MstRd_d         = 32'hDEAD_BEEF;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge PLB_clk);
            check_eq("midreset_no_wr", {31'd0, fifo_wr_en}, 32'd0);
        end
        clear_bus();
        reset   = 1'b1;
        exp_pix = 0;
        serve(0, 0, 1'b0, 1'b0, w, wc);

        // Randomized latencies and errors.
        for (int i = 0; i < 40; i++) begin
            serve($urandom_range(3, 0), $urandom_range(3, 0),
                  ($urandom_range(7, 0) == 0), 1'b0, w, wc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
